// File: rtl/pe_tile_param.sv
// Parametrised PE tile: 4-sided switch box, two connect boxes, 2-input CLB with registered output.
// Double-buffered config (shadow -> active on commit). Optional readback port under CONFIG_READBACK_EN.
module pe_tile_param #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned NUM_TRACKS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    config_addr,
  input  logic [31:0]                    config_data,
  input  logic                           config_we,
  input  logic [15:0]                    tile_id,
  input  logic [4*NUM_TRACKS*WIDTH-1:0]  in_wires,
  output logic [4*NUM_TRACKS*WIDTH-1:0]  out_wires,
  output logic [WIDTH-1:0]               pe_out
`ifdef CONFIG_READBACK_EN
  ,
  output logic [31:0]                    config_rdata
`endif
);

  localparam int unsigned SELW     = $clog2(2*NUM_TRACKS);
  localparam int unsigned NOUT     = 4*NUM_TRACKS;
  localparam int unsigned SB_WORDS = (NOUT + 15) / 16;

  typedef enum logic [7:0] {
    REG_CLB  = 8'd4,
    REG_CB1  = 8'd5,
    REG_CB0  = 8'd6,
    REG_SB   = 8'd7,
    REG_CTRL = 8'd8
  } region_e;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_ADD} clb_op_e;

  logic [7:0] region;
  logic [7:0] word_idx;
  logic       tile_hit, we_hit, idx_zero, sb_idx_ok;
  logic       sb_wr, cb0_wr, cb1_wr, clb_wr, commit;

  logic [1:0]      sb_sh  [NOUT];
  logic [1:0]      sb_act [NOUT];
  logic [SELW-1:0] cb_sh  [2];
  logic [SELW-1:0] cb_act [2];
  clb_op_e         op_sh, op_act;

  logic [WIDTH-1:0] cb_val [2];
  logic [WIDTH-1:0] pe_next;
  logic             unused_cfg;

  assign region    = config_addr[31:24];
  assign word_idx  = config_addr[23:16];
  assign tile_hit  = (config_addr[15:0] == tile_id);
  assign we_hit    = config_we && tile_hit;
  assign idx_zero  = (word_idx == '0);
  assign sb_idx_ok = (32'(word_idx) < SB_WORDS);

  assign sb_wr  = we_hit && (region == REG_SB)  && sb_idx_ok;
  assign cb0_wr = we_hit && (region == REG_CB0) && idx_zero;
  assign cb1_wr = we_hit && (region == REG_CB1) && idx_zero;
  assign clb_wr = we_hit && (region == REG_CLB) && idx_zero;
  assign commit = we_hit && (region == REG_CTRL) && idx_zero && config_data[0];

  // Not every data/address bit is meaningful for every parameterisation.
  assign unused_cfg = ^{config_data, config_addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NOUT; i++) begin
        sb_sh[i]  <= '0;
        sb_act[i] <= '0;
      end
      for (int unsigned n = 0; n < 2; n++) begin
        cb_sh[n]  <= '0;
        cb_act[n] <= '0;
      end
      op_sh  <= OP_AND;
      op_act <= OP_AND;
      pe_out <= '0;
    end else begin
      if (sb_wr) begin
        for (int unsigned i = 0; i < NOUT; i++) begin
          if (i / 16 == 32'(word_idx))
            sb_sh[i] <= config_data[2*(i%16) +: 2];
        end
      end
      if (cb0_wr) cb_sh[0] <= config_data[SELW-1:0];
      if (cb1_wr) cb_sh[1] <= config_data[SELW-1:0];
      if (clb_wr) op_sh    <= clb_op_e'(config_data[1:0]);
      // Commit copies the pre-edge shadow; writes and commits never share a cycle on one bus.
      if (commit) begin
        sb_act <= sb_sh;
        cb_act <= cb_sh;
        op_act <= op_sh;
      end
      pe_out <= pe_next;
    end
  end

  always_comb begin
    out_wires = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
        case (sb_act[s*NUM_TRACKS+t])
          2'd0:    out_wires[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = in_wires[(((s+1)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
          2'd1:    out_wires[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = in_wires[(((s+2)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
          2'd2:    out_wires[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = in_wires[(((s+3)%4)*NUM_TRACKS+t)*WIDTH +: WIDTH];
          default: out_wires[(s*NUM_TRACKS+t)*WIDTH +: WIDTH] = pe_out;
        endcase
      end
    end
  end

  // Connect box n taps side n: low selects read inputs, high selects read this tile's outputs.
  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      cb_val[n] = '0;
      if (32'(cb_act[n]) < NUM_TRACKS)
        cb_val[n] = in_wires[(n*NUM_TRACKS + 32'(cb_act[n]))*WIDTH +: WIDTH];
      else if (32'(cb_act[n]) < 2*NUM_TRACKS)
        cb_val[n] = out_wires[(n*NUM_TRACKS + 32'(cb_act[n]) - NUM_TRACKS)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    pe_next = '0;
    case (op_act)
      OP_AND:  pe_next = cb_val[0] & cb_val[1];
      OP_OR:   pe_next = cb_val[0] | cb_val[1];
      OP_XOR:  pe_next = cb_val[0] ^ cb_val[1];
      default: pe_next = cb_val[0] + cb_val[1];
    endcase
  end

`ifdef CONFIG_READBACK_EN
  logic [31:0] rb_word;

  always_comb begin
    rb_word = '0;
    case (region)
      REG_SB: begin
        if (sb_idx_ok) begin
          for (int unsigned i = 0; i < NOUT; i++) begin
            if (i / 16 == 32'(word_idx))
              rb_word[2*(i%16) +: 2] = sb_sh[i];
          end
        end
      end
      REG_CB0: if (idx_zero) rb_word[SELW-1:0] = cb_sh[0];
      REG_CB1: if (idx_zero) rb_word[SELW-1:0] = cb_sh[1];
      REG_CLB: if (idx_zero) rb_word[1:0]      = op_sh;
      default: rb_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      config_rdata <= '0;
    else if (tile_hit)
      config_rdata <= rb_word;
  end
`endif

endmodule

// File: tb/tb_pe_tile_param.sv
// Self-checking bench for pe_tile_param (WIDTH=4, NUM_TRACKS=3) with a scoreboard queue of expected results.
module tb_pe_tile_param;

  localparam int unsigned W    = 4;
  localparam int unsigned NT   = 3;
  localparam int unsigned NOUT = 4*NT;
  localparam int unsigned OW   = NOUT*W;
  localparam int unsigned SBW  = 1;
  localparam logic [15:0] TILE = 16'h0005;

  logic          clk;
  logic          reset;
  logic [31:0]   config_addr, config_data;
  logic          config_we;
  logic [15:0]   tile_id;
  logic [OW-1:0] in_wires, out_wires;
  logic [W-1:0]  pe_out;
  logic [31:0]   config_rdata;

  pe_tile_param #(.WIDTH(W), .NUM_TRACKS(NT)) dut (
    .clk         (clk),
    .reset       (reset),
    .config_addr (config_addr),
    .config_data (config_data),
    .config_we   (config_we),
    .tile_id     (tile_id),
    .in_wires    (in_wires),
    .out_wires   (out_wires),
    .pe_out      (pe_out)
`ifdef CONFIG_READBACK_EN
    ,
    .config_rdata(config_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [1:0]   m_sb_sh  [NOUT];
  logic [1:0]   m_sb_act [NOUT];
  logic [2:0]   m_cb_sh  [2];
  logic [2:0]   m_cb_act [2];
  logic [1:0]   m_op_sh, m_op_act;
  logic [W-1:0] m_pe;
  logic [31:0]  m_rd;

  typedef struct {
    logic [W-1:0] pe;
    logic [31:0]  rd;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [OW-1:0] m_route(input logic [OW-1:0] inw);
    logic [OW-1:0] r;
    int kk;
    r = '0;
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < NT; t++) begin
        kk = int'(m_sb_act[s*NT+t]);
        if (kk == 3) r[(s*NT+t)*W +: W] = m_pe;
        else         r[(s*NT+t)*W +: W] = inw[(((s+1+kk)%4)*NT+t)*W +: W];
      end
    return r;
  endfunction

  function automatic logic [W-1:0] m_cb(input int sel, input int side,
                                        input logic [OW-1:0] inw, input logic [OW-1:0] outw);
    if (sel < NT)        return inw[(side*NT+sel)*W +: W];
    else if (sel < 2*NT) return outw[(side*NT+sel-NT)*W +: W];
    return '0;
  endfunction

  function automatic logic [W-1:0] m_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return W'((a + b) % (1 << W));
    endcase
  endfunction

  function automatic logic [31:0] m_rb(input logic [31:0] addr);
    logic [31:0] r;
    int idx;
    r = '0;
    idx = int'(addr[23:16]);
    case (addr[31:24])
      8'd7: if (idx < SBW) for (int j = 0; j < 16; j++) if (16*idx+j < NOUT) r[2*j +: 2] = m_sb_sh[16*idx+j];
      8'd6: if (idx == 0) r[2:0] = m_cb_sh[0];
      8'd5: if (idx == 0) r[2:0] = m_cb_sh[1];
      8'd4: if (idx == 0) r[1:0] = m_op_sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_edge(input logic rst, input logic we, input logic [31:0] addr, input logic [31:0] data);
    int idx;
    idx = int'(addr[23:16]);
    if (rst) begin
      for (int i = 0; i < NOUT; i++) begin m_sb_sh[i] = '0; m_sb_act[i] = '0; end
      m_cb_sh[0] = '0; m_cb_sh[1] = '0; m_cb_act[0] = '0; m_cb_act[1] = '0;
      m_op_sh = '0; m_op_act = '0;
      return;
    end
    if (!we || addr[15:0] != TILE) return;
    case (addr[31:24])
      8'd7: if (idx < SBW) for (int j = 0; j < 16; j++) if (16*idx+j < NOUT) m_sb_sh[16*idx+j] = data[2*j +: 2];
      8'd6: if (idx == 0) m_cb_sh[0] = data[2:0];
      8'd5: if (idx == 0) m_cb_sh[1] = data[2:0];
      8'd4: if (idx == 0) m_op_sh = data[1:0];
      8'd8: if (idx == 0 && data[0]) begin
        for (int i = 0; i < NOUT; i++) m_sb_act[i] = m_sb_sh[i];
        m_cb_act[0] = m_cb_sh[0]; m_cb_act[1] = m_cb_sh[1]; m_op_act = m_op_sh;
      end
      default: ;
    endcase
  endtask

  // One clock: drive, push expectation, advance, pop and compare.
  task automatic cyc(input string ph, input logic rst, input logic we, input logic [31:0] addr,
                     input logic [31:0] data, input logic [OW-1:0] inw);
    exp_t e;
    logic [OW-1:0] ow;
    reset = rst; config_we = we; config_addr = addr; config_data = data; in_wires = inw;
    ow   = m_route(inw);
    e.pe = rst ? '0 : m_op(m_op_act, m_cb(int'(m_cb_act[0]), 0, inw, ow), m_cb(int'(m_cb_act[1]), 1, inw, ow));
    e.rd = rst ? '0 : ((addr[15:0] == TILE) ? m_rb(addr) : m_rd);
    sb_q.push_back(e);
    @(posedge clk);
    model_edge(rst, we, addr, data);
    m_pe = e.pe;
    m_rd = e.rd;
    #1;
    e = sb_q.pop_front();
    chk({ph, ".pe_out"}, 64'(pe_out), 64'(e.pe));
`ifdef CONFIG_READBACK_EN
    chk({ph, ".rdata"}, 64'(config_rdata), 64'(e.rd));
`endif
    chk({ph, ".out_wires"}, 64'(out_wires), 64'(m_route(inw)));
  endtask

  function automatic logic [31:0] ad(input logic [7:0] region, input logic [7:0] idx, input logic [15:0] tile);
    return {region, idx, tile};
  endfunction

  function automatic logic [OW-1:0] put(input logic [OW-1:0] v, input int side, input int t, input logic [W-1:0] x);
    logic [OW-1:0] r;
    r = v;
    r[(side*NT+t)*W +: W] = x;
    return r;
  endfunction

  function automatic logic [OW-1:0] rnd_in();
    logic [OW-1:0] r;
    for (int i = 0; i < NOUT; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  logic [OW-1:0] iv;
  logic [31:0]   idle;

  initial begin
    for (int i = 0; i < NOUT; i++) begin m_sb_sh[i] = '0; m_sb_act[i] = '0; end
    m_cb_sh[0] = '0; m_cb_sh[1] = '0; m_cb_act[0] = '0; m_cb_act[1] = '0;
    m_op_sh = '0; m_op_act = '0; m_pe = '0; m_rd = '0;
    tile_id = TILE;
    idle = ad(8'd0, 8'd0, 16'h0000);

    // Reset; side1 track t carries t&1 and must appear on side0.
    iv = rnd_in();
    for (int t = 0; t < NT; t++) iv = put(iv, 1, t, W'(t & 1));
    cyc("rst0", 1'b1, 1'b0, idle, 32'h0, iv);
    cyc("rst1", 1'b1, 1'b0, idle, 32'h0, iv);
    cyc("idle", 1'b0, 1'b0, idle, 32'h0, iv);
    for (int t = 0; t < NT; t++) chk("t1_mirror", 64'(out_wires[t*W +: W]), 64'(t & 1));
    chk("t1_pe_zero", 64'(pe_out), 64'h0);

    // SB all-ones: invisible until commit, then every output track follows pe_out.
    cyc("t2_wr", 1'b0, 1'b1, ad(8'd7, 8'd0, TILE), 32'hFFFF_FFFF, rnd_in());
    cyc("t2_hold", 1'b0, 1'b0, idle, 32'h0, rnd_in());
    cyc("t2_nocommit", 1'b0, 1'b1, ad(8'd8, 8'd0, TILE), 32'h0000_0000, rnd_in());
    cyc("t2_commit", 1'b0, 1'b1, ad(8'd8, 8'd0, TILE), 32'h0000_0001, rnd_in());
    for (int i = 0; i < 3; i++) cyc("t2_after", 1'b0, 1'b0, idle, 32'h0, rnd_in());

    // CB0=0, CB1=1, ADD: 9 + 8 = 1 mod 16.
    cyc("t3_cb0", 1'b0, 1'b1, ad(8'd6, 8'd0, TILE), 32'h0, rnd_in());
    cyc("t3_cb1", 1'b0, 1'b1, ad(8'd5, 8'd0, TILE), 32'h1, rnd_in());
    cyc("t3_clb", 1'b0, 1'b1, ad(8'd4, 8'd0, TILE), 32'h3, rnd_in());
    cyc("t3_commit", 1'b0, 1'b1, ad(8'd8, 8'd0, TILE), 32'h1, rnd_in());
    iv = put(put(rnd_in(), 0, 0, 4'd9), 1, 1, 4'd8);
    cyc("t3_add", 1'b0, 1'b0, idle, 32'h0, iv);
    chk("t3_add_value", 64'(pe_out), 64'h1);

    // Misses: wrong tile, SB index out of range; readback keeps old values.
    cyc("t4_badtile", 1'b0, 1'b1, ad(8'd6, 8'd0, TILE + 16'd1), 32'h5, rnd_in());
    cyc("t4_badidx", 1'b0, 1'b1, ad(8'd7, 8'd1, TILE), 32'h0, rnd_in());
    cyc("t4_rd_cb0", 1'b0, 1'b0, ad(8'd6, 8'd0, TILE), 32'h0, rnd_in());
    cyc("t4_rd_sb", 1'b0, 1'b0, ad(8'd7, 8'd0, TILE), 32'h0, rnd_in());
`ifdef CONFIG_READBACK_EN
    chk("t4_rb_sb_old", 64'(config_rdata), 64'h0000_0000_00FF_FFFF);
`endif
    cyc("t4_commit", 1'b0, 1'b1, ad(8'd8, 8'd0, TILE), 32'h1, rnd_in());
    cyc("t4_after", 1'b0, 1'b0, idle, 32'h0, rnd_in());

    // CB0 sel NT+2 taps out side0 track2; sel 2*NT yields a zero operand.
    cyc("t5_sb", 1'b0, 1'b1, ad(8'd7, 8'd0, TILE), 32'h0, rnd_in());
    cyc("t5_cb0", 1'b0, 1'b1, ad(8'd6, 8'd0, TILE), 32'(NT + 2), rnd_in());
    cyc("t5_cb1", 1'b0, 1'b1, ad(8'd5, 8'd0, TILE), 32'(2*NT), rnd_in());
    cyc("t5_clb", 1'b0, 1'b1, ad(8'd4, 8'd0, TILE), 32'h1, rnd_in());
    cyc("t5_commit", 1'b0, 1'b1, ad(8'd8, 8'd0, TILE), 32'h1, rnd_in());
    iv = put(rnd_in(), 1, 2, 4'hA);
    cyc("t5_tap", 1'b0, 1'b0, idle, 32'h0, iv);
    chk("t5_out_tap", 64'(pe_out), 64'hA);
    cyc("t5_zero_cb0", 1'b0, 1'b1, ad(8'd6, 8'd0, TILE), 32'(2*NT), rnd_in());
    cyc("t5_commit2", 1'b0, 1'b1, ad(8'd8, 8'd0, TILE), 32'h1, rnd_in());
    cyc("t5_zero", 1'b0, 1'b0, idle, 32'h0, rnd_in());
    chk("t5_zero_operands", 64'(pe_out), 64'h0);

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      logic [7:0]  rg;
      logic [7:0]  ix;
      logic [15:0] tl;
      case ($urandom_range(0, 5))
        0: rg = 8'd4; 1: rg = 8'd5; 2: rg = 8'd6; 3: rg = 8'd7; 4: rg = 8'd8; default: rg = 8'd0;
      endcase
      ix = (rg == 8'd7) ? 8'($urandom_range(0, 1)) : 8'd0;
      tl = ($urandom_range(0, 3) == 0) ? TILE + 16'd2 : TILE;
      cyc("rand", 1'b0, 1'($urandom_range(0, 1)), ad(rg, ix, tl), $urandom, rnd_in());
    end

    // Reset during a commit cycle wins; then CB1 readback after one cycle.
    cyc("t6_sb", 1'b0, 1'b1, ad(8'd7, 8'd0, TILE), 32'hAAAA_AAAA, rnd_in());
    cyc("t6_cb1", 1'b0, 1'b1, ad(8'd5, 8'd0, TILE), 32'h3, rnd_in());
    iv = rnd_in();
    cyc("t6_rst_commit", 1'b1, 1'b1, ad(8'd8, 8'd0, TILE), 32'h1, iv);
    cyc("t6_after", 1'b0, 1'b0, idle, 32'h0, iv);
    for (int t = 0; t < NT; t++) chk("t6_default_route", 64'(out_wires[t*W +: W]), 64'(iv[(NT+t)*W +: W]));
    cyc("t6_wr_cb1", 1'b0, 1'b1, ad(8'd5, 8'd0, TILE), 32'h4, rnd_in());
    cyc("t6_rd_cb1", 1'b0, 1'b0, ad(8'd5, 8'd0, TILE), 32'h0, rnd_in());
`ifdef CONFIG_READBACK_EN
    chk("t6_rb_cb1", 64'(config_rdata), 64'h4);
`endif
    cyc("t6_rd_ctrl", 1'b0, 1'b0, ad(8'd8, 8'd0, TILE), 32'h0, rnd_in());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
